// File: rtl/board_shift_engine.sv
// board_shift_engine: sequential 2048 slide-and-merge move engine.
// Captures an N x N board of tile exponents, processes one line per enabled
// clock in the requested direction, then presents the new board with a
// moved flag and a one-cycle done pulse.
// Optional feature macro: MOVE_SCORE_EN builds the saturating score adder;
// without it score_add is tied to zero.
module board_shift_engine #(
  parameter int N       = 4,
  parameter int EW      = 4,
  parameter int SCORE_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                start,
  input  logic                up,
  input  logic                down,
  input  logic                left,
  input  logic                right,
  input  logic [N*N*EW-1:0]   in_tiles,
  output logic [N*N*EW-1:0]   out_tiles,
  output logic                busy,
  output logic                done,
  output logic                moved,
  output logic [SCORE_W-1:0]  score_add
);

  localparam int LW = (N > 2) ? $clog2(N) : 1;
  localparam logic [EW-1:0] EMAX = '1;

  localparam logic [1:0] D_UP    = 2'd0;
  localparam logic [1:0] D_DOWN  = 2'd1;
  localparam logic [1:0] D_LEFT  = 2'd2;
  localparam logic [1:0] D_RIGHT = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  // Board index of the k-th tile of a line, counted from the leading edge.
  function automatic int cell_idx(input logic [1:0] dir, input int line, input int k);
    case (dir)
      D_UP:    return k * N + line;
      D_DOWN:  return (N - 1 - k) * N + line;
      D_LEFT:  return line * N + k;
      default: return line * N + (N - 1 - k);
    endcase
  endfunction

  state_t              r_state;
  logic [1:0]          r_dir;
  logic [LW-1:0]       r_line_cnt;
  logic [N*N*EW-1:0]   r_board;
  logic [N*N*EW-1:0]   r_out;
  logic                r_busy;
  logic                r_done;
  logic                r_moved;

  logic [EW-1:0]       w_cells    [N*N];
  logic [EW-1:0]       w_cells_nx [N*N];
  logic [EW-1:0]       w_line     [N];
  logic [EW-1:0]       w_comp     [N+1];
  logic [EW-1:0]       w_res      [N];
  logic [N*N*EW-1:0]   w_board_nx;
  logic                w_changed;
  logic                w_dir_ok;
  logic                w_accept;
  logic [1:0]          w_dir_code;
`ifdef MOVE_SCORE_EN
  logic [N-1:0]        w_merged;
  logic [SCORE_W-1:0]  w_line_score;
  logic [SCORE_W-1:0]  r_score;
`endif

  // Request decode: exactly one direction must accompany start.
  always_comb begin
    w_dir_ok = $onehot({up, down, left, right});
    w_accept = (r_state == S_IDLE) && start && w_dir_ok;
    if (up)        w_dir_code = D_UP;
    else if (down) w_dir_code = D_DOWN;
    else if (left) w_dir_code = D_LEFT;
    else           w_dir_code = D_RIGHT;
  end

  // Unpack the working board and gather the current line in motion order.
  always_comb begin
    for (int i = 0; i < N * N; i++) begin
      w_cells[i] = r_board[(N*N-1-i)*EW +: EW];
    end
    for (int k = 0; k < N; k++) begin
      w_line[k] = w_cells[cell_idx(r_dir, int'(r_line_cnt), k)];
    end
  end

  // Compact toward the leading edge, then merge leading-first, once per tile.
  always_comb begin
    int  cnt;
    int  o;
    logic skip;
    cnt  = 0;
    o    = 0;
    skip = 1'b0;
    for (int k = 0; k <= N; k++) begin
      w_comp[k] = '0;
    end
    for (int k = 0; k < N; k++) begin
      w_res[k] = '0;
    end
`ifdef MOVE_SCORE_EN
    w_merged = '0;
`endif
    for (int k = 0; k < N; k++) begin
      if (w_line[k] != '0) begin
        w_comp[cnt] = w_line[k];
        cnt = cnt + 1;
      end
    end
    // w_comp[N] stays zero, so the pair test never needs a bounds guard.
    for (int k = 0; k < N; k++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (w_comp[k] != '0) begin
        if (w_comp[k+1] == w_comp[k] && w_comp[k] != EMAX) begin
          w_res[o] = w_comp[k] + 1'b1;
`ifdef MOVE_SCORE_EN
          w_merged[o] = 1'b1;
`endif
          skip = 1'b1;
        end else begin
          w_res[o] = w_comp[k];
        end
        o = o + 1;
      end
    end
  end

  // Write the processed line back and flag whether it differs.
  always_comb begin
    w_cells_nx = w_cells;
    w_changed  = 1'b0;
    w_board_nx = '0;
    for (int k = 0; k < N; k++) begin
      w_cells_nx[cell_idx(r_dir, int'(r_line_cnt), k)] = w_res[k];
      if (w_res[k] != w_line[k]) w_changed = 1'b1;
    end
    for (int i = 0; i < N * N; i++) begin
      w_board_nx[(N*N-1-i)*EW +: EW] = w_cells_nx[i];
    end
  end

  // Move sequencer: capture in IDLE, one line per cycle in RUN, publish in FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_dir      <= D_UP;
      r_line_cnt <= '0;
      r_out      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_moved    <= 1'b0;
    end else if (enable) begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_board    <= in_tiles;
            r_dir      <= w_dir_code;
            r_line_cnt <= '0;
            r_moved    <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_board <= w_board_nx;
          if (w_changed) r_moved <= 1'b1;
          if (r_line_cnt == LW'(N - 1)) begin
            r_state <= S_FIN;
          end else begin
            r_line_cnt <= r_line_cnt + 1'b1;
          end
        end
        S_FIN: begin
          r_out   <= r_board;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MOVE_SCORE_EN
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

  function automatic logic [SCORE_W-1:0] pow2_sat(input logic [EW-1:0] e);
    if (int'(e) >= SCORE_W) return {SCORE_W{1'b1}};
    return SCORE_W'(1) << e;
  endfunction

  // Score contributed by the current line: 2^(new exponent) per merge.
  always_comb begin
    w_line_score = '0;
    for (int k = 0; k < N; k++) begin
      if (w_merged[k]) w_line_score = sat_add(w_line_score, pow2_sat(w_res[k]));
    end
  end

  // Running move score, cleared on an accepted start and held afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_score <= '0;
    end else if (enable) begin
      if (w_accept) begin
        r_score <= '0;
      end else if (r_state == S_RUN) begin
        r_score <= sat_add(r_score, w_line_score);
      end
    end
  end

  assign score_add = r_score;
`else
  assign score_add = '0;
`endif

  assign out_tiles = r_out;
  assign busy      = r_busy;
  assign done      = r_done;
  assign moved     = r_moved;

endmodule

// File: doc/board_shift_engine.md
# board_shift_engine

Parametrised sequential 2048 move engine: takes an N×N board of tile exponents, applies one slide-and-merge move (up/down/left/right) one line per clock, and returns the new board with a moved flag and the move's score. It sits between the debounced button/direction logic and the board register / random-tile spawner. It generalises the combinational 4×4 movement block in three ways: configurable grid size and exponent width, a start/busy/done handshake, and stall support.

## Interface
- `N`, default 4: grid dimension (N×N tiles), 2..8.
- `EW`, default 4: exponent width per tile; 0 = empty, max exponent `2^EW-1`.
- `SCORE_W`, default 24: width of `score_add`.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  global advance; low freezes the FSM and all registers.
- `start`  in  1  request a move; sampled only in IDLE with `enable`=1.
- `up`, `down`, `left`, `right`  in  1 each  direction; sampled with `start`, exactly one must be high.
- `in_tiles`  in  N*N*EW  board; tile (r,c), i=r*N+c, at bits [(N*N-1-i)*EW +: EW] (row 0 col 0 in MSBs).
- `out_tiles`  out  N*N*EW  result board, same packing.
- `busy`  out  1  move in progress.
- `done`  out  1  one-cycle pulse; results valid.
- `moved`  out  1  `out_tiles` differs from the captured board.
- `score_add`  out  SCORE_W  sum of 2^(new exponent) over all merges in the move, saturating.

## Operation
- States: IDLE, RUN, FIN.
- IDLE: if `enable`, `start`, and exactly one direction is high: capture `in_tiles` and direction into the working board; clear `line_cnt`, `moved`, and `score_add`; go to RUN.
  - Invalid direction (none or several high): request ignored, stay IDLE, no `done`.
- RUN: each enabled cycle processes line `line_cnt`.
  - Line mapping: column for up/down, row for left/right.
  - Tiles are read in the direction of motion (up: row 0→N-1; down: N-1→0; left: col 0→N-1; right: N-1→0).
- Per-line algorithm:
  - Compact non-zero tiles toward the leading edge.
  - Scan from the leading edge; two adjacent equal exponents e (e≠0, e<2^EW-1) merge into e+1.
  - Each tile merges at most once per move; pairing is leading-first (1,1,1 → 2,1).
  - Tiles at max exponent 2^EW-1 never merge.
- Results per line: write the line back; set `moved` if it changed; add 2^(e+1) to the score per merge, saturating at 2^SCORE_W-1.
- After line N-1: go to FIN.
- FIN: drive `out_tiles` from the working board, pulse `done`, return to IDLE.
- Hold: `out_tiles`, `moved`, and `score_add` hold until the next accepted start.
- `start` while busy is ignored; `in_tiles` changes after capture are ignored.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `moved`=0, `score_add`=0, `out_tiles`=0.
- Start accepted at edge E.
- `busy`=1 after edge E.
- Lines are processed at edges E+1..E+N.
- `done`=1 and `busy`=0 for exactly the one cycle after edge E+N+1.
- Latency is N+1 cycles with `enable` continuously high. Each enable-low cycle adds one cycle; a `done` pulse in progress extends while stalled.
- `rst` mid-move aborts immediately to the reset values; no `done`.
- `done` and a new `start` may coincide (FSM is in IDLE during the `done` cycle). The new request is accepted at that edge.

## Configuration
- `MOVE_SCORE_EN` defined: score adder and saturation logic present; `score_add` behaves as above.
- `MOVE_SCORE_EN` undefined: `score_add` is tied to 0 and no adder logic is built. Board, `moved`, and timing are unchanged.

## Test plan
All scenarios use N=4, EW=4; boards are listed row 0 first.
- Diagonal up: board 0000/1000/0100/0010 with `up` → 1110/0000/0000/0000, `moved`=1, `score_add`=0, `done` 5 cycles after start.
- Mixed up: board 1101/0010/1200/1011 with `up` → 2122/1200/0000/0000, `moved`=1, `score_add`=12.
- Single merge per tile: row 1111 with `left` → 2200; row 1111 with `right` → 0022; `score_add`=8 each.
- Max exponent and no-move: row FF00 with `left` → unchanged, `moved`=0, `score_add`=0; board 1000/0000/0000/0000 with `up` → `moved`=0, `done` still pulses.
- Handshake: `start` with up+left both high → no `busy`, no `done`. `start` while busy → ignored. `enable` low for 3 cycles mid-move → `done` at 8 cycles.
- Reset: `rst` at cycle 2 of a move → `busy`/`done`/`out_tiles`/`score_add` all 0, no `done`. A following start completes normally.
